// File: rtl/sfx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sfx_pkg
// Brief    : State encoding, tone codes and jingle note tables for sfx_sequencer
// Revision : 1.0
// ============================================================================
package sfx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MOVE = 3'd1,
        ST_BEEP = 3'd2,
        ST_WIN  = 3'd3,
        ST_OVER = 3'd4
    } state_t;

    localparam logic [2:0] TONE_OFF   = 3'd0;
    localparam logic [2:0] TONE_UP    = 3'd1;
    localparam logic [2:0] TONE_DOWN  = 3'd2;
    localparam logic [2:0] TONE_RIGHT = 3'd3;
    localparam logic [2:0] TONE_LEFT  = 3'd4;
    localparam logic [2:0] TONE_BEEP  = 3'd6;

    // Entry [0] is played first; unused OVER slot is padded with silence.
    localparam logic [3:0][2:0] WIN_NOTES  = {3'd5, 3'd3, 3'd2, 3'd1};
    localparam logic [3:0][2:0] OVER_NOTES = {3'd0, 3'd1, 3'd3, 3'd5};
    localparam int              WIN_LEN    = 4;
    localparam int              OVER_LEN   = 3;
    localparam logic [1:0]      WIN_LAST   = 2'(WIN_LEN - 1);
    localparam logic [1:0]      OVER_LAST  = 2'(OVER_LEN - 1);

    // btns = {up, down, right, left}; up has the highest priority.
    function automatic logic [2:0] key_tone(input logic [3:0] b);
        if (b[3])      return TONE_UP;
        else if (b[2]) return TONE_DOWN;
        else if (b[1]) return TONE_RIGHT;
        else if (b[0]) return TONE_LEFT;
        else           return TONE_OFF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfx_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : sfx_sequencer_if
// Brief    : Game-event inputs and Audio-drive outputs of the sound sequencer
// Revision : 1.0
// ============================================================================
interface sfx_sequencer_if;
    logic [3:0] btns;
    logic       collide;
    logic       level_win;
    logic       game_over;
    logic       en_i;
    logic [2:0] sel;
    logic       audio_en;
    logic       busy;
    logic       freeze;

    modport master (
        output btns, collide, level_win, game_over, en_i,
        input  sel, audio_en, busy, freeze
    );

    modport slave (
        input  btns, collide, level_win, game_over, en_i,
        output sel, audio_en, busy, freeze
    );
endinterface
`default_nettype wire

// File: rtl/note_timer.sv
`default_nettype none
// ============================================================================
// Module   : note_timer
// Brief    : Loadable down-counter; expire pulses while enabled at zero
// Revision : 1.0
// ============================================================================
module note_timer #(
    parameter int CNT_W = 24
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [CNT_W-1:0] load_val,
    input  wire logic             tick_en,
    output logic                  expire
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (tick_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Loading N-1 and expiring at 0 yields exactly N enabled cycles.
    assign expire = tick_en && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sfx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sfx_sequencer
// Brief    : Priority arbiter driving the single Audio tone generator
// Revision : 1.0
// ============================================================================
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int NOTE_TICKS = 12_500_000,
    parameter int BEEP_TICKS = 5_000_000,
    parameter int CNT_W      = 24
) (
    input  wire logic     clk,
    input  wire logic     rst,
    sfx_sequencer_if.slave bus
);

    state_t           r_state;
    logic [1:0]       r_note;
    logic [2:0]       r_sel;
    logic             r_audio_en;
    logic             r_busy;
    logic             r_freeze;

    logic             w_in_jingle;
    logic             w_go_over;
    logic             w_go_win;
    logic             w_go_beep;
    logic             w_expire;
    logic             w_last_note;
    logic [1:0]       w_note_next;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;

    assign w_in_jingle = (r_state == ST_WIN) || (r_state == ST_OVER);
    assign w_go_over   = bus.game_over && (r_state != ST_OVER);
    assign w_go_win    = bus.level_win && !w_in_jingle;
    assign w_go_beep   = bus.collide && !w_in_jingle;
    assign w_last_note = ((r_state == ST_WIN)  && (r_note == WIN_LAST)) ||
                         ((r_state == ST_OVER) && (r_note == OVER_LAST));
    assign w_note_next = (r_note == 2'd3) ? r_note : r_note + 2'd1;

    always_comb begin
        w_load     = w_go_over || w_go_win || w_go_beep ||
                     (w_in_jingle && w_expire && !w_last_note);
        w_load_val = CNT_W'(NOTE_TICKS - 1);
        if (w_go_beep && !w_go_over && !w_go_win) begin
            w_load_val = CNT_W'(BEEP_TICKS - 1);
        end
    end

    note_timer #(
        .CNT_W    (CNT_W)
    ) u_note_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .tick_en  (r_busy),
        .expire   (w_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_note     <= 2'd0;
            r_sel      <= TONE_OFF;
            r_audio_en <= 1'b0;
            r_busy     <= 1'b0;
            r_freeze   <= 1'b0;
        end else begin
            r_audio_en <= bus.en_i;
            if (w_go_over) begin
                r_state  <= ST_OVER;
                r_note   <= 2'd0;
                r_sel    <= OVER_NOTES[0];
                r_busy   <= 1'b1;
                r_freeze <= 1'b1;
            end else if (w_go_win) begin
                r_state  <= ST_WIN;
                r_note   <= 2'd0;
                r_sel    <= WIN_NOTES[0];
                r_busy   <= 1'b1;
                r_freeze <= 1'b1;
            end else if (w_go_beep) begin
                r_state  <= ST_BEEP;
                r_note   <= 2'd0;
                r_sel    <= TONE_BEEP;
                r_busy   <= 1'b1;
                r_freeze <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_MOVE: begin
                        if (bus.btns != 4'd0) begin
                            r_state <= ST_MOVE;
                            r_sel   <= key_tone(bus.btns);
                        end else begin
                            r_state    <= ST_IDLE;
                            r_sel      <= TONE_OFF;
                            r_audio_en <= 1'b0;
                        end
                    end
                    ST_BEEP, ST_WIN, ST_OVER: begin
                        // A finished effect always passes through IDLE, even with keys held.
                        if (w_expire && (r_state == ST_BEEP || w_last_note)) begin
                            r_state    <= ST_IDLE;
                            r_note     <= 2'd0;
                            r_sel      <= TONE_OFF;
                            r_audio_en <= 1'b0;
                            r_busy     <= 1'b0;
                            r_freeze   <= 1'b0;
                        end else if (w_expire) begin
                            r_note <= w_note_next;
                            r_sel  <= (r_state == ST_WIN) ? WIN_NOTES[w_note_next]
                                                          : OVER_NOTES[w_note_next];
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_note     <= 2'd0;
                        r_sel      <= TONE_OFF;
                        r_audio_en <= 1'b0;
                        r_busy     <= 1'b0;
                        r_freeze   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sel      = r_sel;
    assign bus.audio_en = r_audio_en;
    assign bus.busy     = r_busy;
    assign bus.freeze   = r_freeze;

endmodule
`default_nettype wire

// File: tb/tb_sfx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfx_sequencer
// Brief    : Directed plan plus random traffic against a playback-queue model
// Revision : 1.0
// ============================================================================
module tb_sfx_sequencer;

    localparam int NOTE = 4;
    localparam int BEEP = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    sfx_sequencer_if bus ();

    sfx_sequencer #(
        .NOTE_TICKS (NOTE),
        .BEEP_TICKS (BEEP),
        .CNT_W      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: an effect is a queue of per-cycle tones; kind 0 none, 1 beep, 2 win, 3 over.
    int         kind = 0;
    int         q[$];
    int         win_tbl[4]  = '{1, 2, 3, 5};
    int         over_tbl[3] = '{5, 3, 1};
    logic [2:0] exp_sel;
    logic       exp_aen, exp_busy, exp_frz;

    function automatic logic [2:0] ref_key(input logic [3:0] b);
        if (b[3]) return 3'd1;
        if (b[2]) return 3'd2;
        if (b[1]) return 3'd3;
        if (b[0]) return 3'd4;
        return 3'd0;
    endfunction

    task automatic model(input logic [3:0] b, input logic c, w, g, en, rn);
        bit ended = 0;
        if (!rn) begin
            kind = 0; q.delete();
            exp_sel = 0; exp_aen = 0; exp_busy = 0; exp_frz = 0;
            return;
        end
        if (g && kind != 3) begin
            kind = 3; q.delete();
            foreach (over_tbl[i]) repeat (NOTE) q.push_back(over_tbl[i]);
        end else if (w && kind < 2) begin
            kind = 2; q.delete();
            foreach (win_tbl[i]) repeat (NOTE) q.push_back(win_tbl[i]);
        end else if (c && kind < 2) begin
            kind = 1; q.delete();
            repeat (BEEP) q.push_back(6);
        end else if (kind != 0) begin
            void'(q.pop_front());
            if (q.size() == 0) begin kind = 0; ended = 1; end
        end
        if (kind != 0) begin
            exp_sel = 3'(q[0]); exp_aen = en; exp_busy = 1; exp_frz = (kind >= 2);
        end else if (ended) begin
            exp_sel = 0; exp_aen = 0; exp_busy = 0; exp_frz = 0;
        end else begin
            exp_sel = ref_key(b); exp_aen = en && (b != 0); exp_busy = 0; exp_frz = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step(input logic [3:0] b, input logic c, w, g, en, rn);
        bus.btns = b; bus.collide = c; bus.level_win = w; bus.game_over = g;
        bus.en_i = en; rst = rn;
        model(b, c, w, g, en, rn);
        @(posedge clk);
        #1;
        chk("sel", bus.sel, exp_sel);
        chk("audio_en", {2'b0, bus.audio_en}, {2'b0, exp_aen});
        chk("busy", {2'b0, bus.busy}, {2'b0, exp_busy});
        chk("freeze", {2'b0, bus.freeze}, {2'b0, exp_frz});
    endtask

    task automatic idle(input int n);
        repeat (n) step(4'b0000, 0, 0, 0, 1, 1);
    endtask

    initial begin
        bus.btns = 0; bus.collide = 0; bus.level_win = 0; bus.game_over = 0; bus.en_i = 1;

        // Reset dominates held keys; first free edge starts MOVE.
        step(4'b1000, 0, 0, 0, 1, 0);
        step(4'b1000, 0, 0, 0, 1, 0);
        chk("rst_sel", bus.sel, 3'd0);
        chk("rst_aen", {2'b0, bus.audio_en}, 3'd0);
        step(4'b1000, 0, 0, 0, 1, 1);
        chk("move_up", bus.sel, 3'd1);

        step(4'b0101, 0, 0, 0, 1, 1);
        chk("move_down", bus.sel, 3'd2);
        step(4'b0000, 0, 0, 0, 1, 1);
        chk("release", bus.sel, 3'd0);
        chk("release_aen", {2'b0, bus.audio_en}, 3'd0);

        // WIN jingle with a collide at cycle 6 that must be dropped.
        step(4'b0000, 0, 1, 0, 1, 1);
        chk("win_k0", bus.sel, 3'd1);
        for (int k = 1; k < 16; k++) begin
            step(4'b0000, (k == 6), 0, 0, 1, 1);
            chk("win_seq", bus.sel, 3'(win_tbl[k / 4]));
            chk("win_frz", {2'b0, bus.freeze}, 3'd1);
        end
        step(4'b0000, 0, 0, 0, 1, 1);
        chk("win_end", bus.sel, 3'd0);
        chk("win_end_frz", {2'b0, bus.freeze}, 3'd0);

        // game_over during WIN note 2 preempts.
        step(4'b0000, 0, 1, 0, 1, 1);
        for (int k = 1; k < 5; k++) step(4'b0000, 0, 0, 0, 1, 1);
        step(4'b0000, 0, 0, 1, 1, 1);
        chk("over_k0", bus.sel, 3'd5);
        for (int k = 1; k < 12; k++) begin
            step(4'b0000, 0, 0, 0, 1, 1);
            chk("over_seq", bus.sel, 3'(over_tbl[k / 4]));
        end
        step(4'b0010, 0, 0, 0, 1, 1);
        chk("over_end", bus.sel, 3'd0);
        step(4'b0010, 0, 0, 0, 1, 1);
        chk("held_after", bus.sel, 3'd3);
        idle(1);

        // Retriggered beep: 5 cycles of tone 6.
        step(4'b0000, 1, 0, 0, 1, 1);
        step(4'b0000, 0, 0, 0, 1, 1);
        step(4'b0000, 1, 0, 0, 1, 1);
        step(4'b0000, 0, 0, 0, 1, 1);
        step(4'b0000, 0, 0, 0, 1, 1);
        chk("beep_5th", bus.sel, 3'd6);
        step(4'b0000, 0, 0, 0, 1, 1);
        chk("beep_end", bus.sel, 3'd0);

        // Muted beep: tone still selected, enable low.
        for (int k = 0; k < 3; k++) begin
            step(4'b0000, (k == 0), 0, 0, 0, 1);
            chk("mute_sel", bus.sel, 3'd6);
            chk("mute_aen", {2'b0, bus.audio_en}, 3'd0);
        end
        step(4'b0000, 0, 0, 0, 0, 1);
        chk("mute_end", bus.sel, 3'd0);

        // Reset mid-jingle silences immediately.
        step(4'b0000, 0, 1, 0, 1, 1);
        idle(3);
        step(4'b0000, 0, 0, 0, 1, 0);
        chk("rst_mid", bus.sel, 3'd0);
        idle(2);

        // Random traffic against the model.
        begin
            logic [3:0] b;
            logic       en;
            b = 0; en = 1;
            for (int n = 0; n < 1500; n++) begin
                if ($urandom_range(0, 7) == 0)  b  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
                if ($urandom_range(0, 19) == 0) en = ~en;
                step(b,
                     ($urandom_range(0, 14) == 0),
                     ($urandom_range(0, 39) == 0),
                     ($urandom_range(0, 59) == 0),
                     en,
                     ($urandom_range(0, 99) != 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sfx_sequencer.md
# sfx_sequencer

Sound-effect sequencer and arbiter for the game's single `Audio` tone generator. It accepts direction-key activity from the PS/2 interface and event pulses from the game logic (wall collision, level passed, game over), then arbitrates them by fixed priority. Each winning request is played as either a held tone or a timed note sequence. The output is the 3-bit tone select and enable that drive `Audio` in place of the raw `Decoder_4to3` path.

## Interface
- `NOTE_TICKS`, default 12_500_000: cycles per jingle note (125 ms at 100 MHz).
- `BEEP_TICKS`, default 5_000_000: cycles for the collision beep.
- `CNT_W`, default 24: timer width; must satisfy 2^CNT_W > max(NOTE_TICKS, BEEP_TICKS).
- `clk` in, 1: system clock, 100 MHz.
- `rst` in, 1: reset, synchronous, active-low.
- `btns` in, 4: {up, down, right, left} key-held levels from the PS/2 interface.
- `collide` in, 1: one-cycle pulse when the player hits a wall.
- `level_win` in, 1: one-cycle pulse when the level is passed.
- `game_over` in, 1: one-cycle pulse when the player loses.
- `en_i` in, 1: sound-enable switch.
- `sel` out, 3: tone select to `Audio`; 0 means silence.
- `audio_en` out, 1: enable to `Audio`.
- `busy` out, 1: high while a beep or jingle is playing.
- `freeze` out, 1: high during WIN and OVER; the player object gates movement with it.

## Operation
- States: IDLE, MOVE, BEEP, WIN, OVER.
- Priority, highest first: game_over > level_win > collide > btns.
- Any state, `game_over` asserted: go to OVER, note index 0, timer loaded with NOTE_TICKS.
- Any state except OVER, `level_win` asserted: go to WIN, note 0.
- Any state except WIN and OVER, `collide` asserted: go to BEEP, timer loaded with BEEP_TICKS. A `collide` during BEEP restarts the timer.
- A `level_win` during WIN is ignored.
- A `game_over` during OVER is ignored.
- Lower-priority pulses that arrive during higher-priority playback are dropped, not queued.
- IDLE with any `btns` bit set: go to MOVE.
- MOVE: `sel` tracks the highest-priority held key every cycle: up=1, down=2, right=3, left=4. When all keys are released, go to IDLE.
- BEEP: `sel`=6. On timer expiry, go to IDLE.
- WIN jingle: notes 1, 2, 3, 5, each held NOTE_TICKS cycles. After the last note expires, go to IDLE.
- OVER jingle: notes 5, 3, 1, each held NOTE_TICKS cycles. After the last note expires, go to IDLE.
- `busy` is high in BEEP, WIN and OVER.
- `audio_en` = `en_i` AND (state != IDLE).
- `sel` updates independently of `en_i`.
- Timer: down-counter loaded with N-1 and expiring at 0, giving exactly N cycles per note. The note index is 2 bits and saturates at the last entry.

## Timing
- All outputs are registered.
- Reset values: `sel`=0, `audio_en`=0, `busy`=0, `freeze`=0, state IDLE, timer 0, note index 0.
- Reset has priority over every input in the same cycle.
- Latency: a request sampled at edge t takes effect on the outputs after edge t+1. Key release in MOVE gives `sel`=0 one cycle later.
- Simultaneous pulses resolve by priority in the same cycle; the loser is discarded.
- A preempted jingle or beep does not resume.
- Expiry and a new pulse in the same cycle: the pulse wins. The state goes to the pulse's target, not IDLE.
- After the last jingle note, `sel`=0 and `busy`=0 appear on the edge after expiry.
- Keys still held at that point take effect one cycle later, via IDLE → MOVE.
- `rst` mid-jingle: silence on the next edge, no residual state.

## Structure
- Package `sfx_pkg` holds:
  - the state encoding,
  - the tone codes (TONE_UP..TONE_LEFT = 1..4, TONE_BEEP = 6),
  - the WIN and OVER note tables with their lengths.
- One sub-module, `note_timer`, with ports: load, load value, tick enable, expire pulse; parameter CNT_W.
- The arbitration FSM stays in `sfx_sequencer`.

## Test plan
Bench parameters: NOTE_TICKS=4, BEEP_TICKS=3, `en_i`=1 unless stated.
- Reset held 2 cycles while `btns`=4'b1000 → `sel`=0, `audio_en`=0. After release: `sel`=1 one cycle later.
- `btns`=4'b0101 → `sel`=2. Then `btns`=0 → `sel`=0 next cycle, state IDLE.
- `level_win` pulse → `sel` sequence 1, 2, 3, 5, each for 4 cycles; `freeze`=1 for 16 cycles, then 0. A `collide` pulse at cycle 6 is ignored.
- During WIN note 2, `game_over` pulse → next cycle `sel`=5. Sequence 5, 3, 1 follows, then IDLE.
- `collide`, then a second `collide` 2 cycles later → `sel`=6 for 5 cycles total, then 0.
- `en_i`=0 and `collide` → `sel`=6 for 3 cycles, `audio_en`=0 throughout.
